// File: rtl/bcd_counter_ctrl.sv
// Wishbone-slave sequencer for the 4-digit BCD counter in the user area.
// Generates the counter's count-enable tick from a programmable prescaler,
// issues parallel-load and clear pulses, and watches the counter output for a
// programmable compare match (interrupt plus optional auto-reload).
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_*                   Wishbone slave (single-cycle ack, 6-register window)
//   cnt_value               counter BCD output {thousands,hundreds,tens,units}
//   cnt_reset               synchronous clear pulse to the counter
//   cnt_load/_value         one-cycle parallel-load pulse and BCD value (LOAD reg)
//   cnt_tick                one-cycle count-enable pulse
//   irq_o                   level interrupt = STATUS.match & CTRL.irq_en
module bcd_counter_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_FFE0,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [15:0] cnt_value,
  output logic        cnt_reset,
  output logic        cnt_load,
  output logic [15:0] cnt_load_value,
  output logic        cnt_tick,
  output logic        irq_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t state, state_next;

  // Architectural registers
  logic          run, irq_en, auto_reload;
  logic [CW-1:0] load_reg, prescale_reg, compare_reg;
  logic          match, bcd_err;

  // Internal state and registered outputs
  logic [CW-1:0] presc;
  logic          sample_pend;
  logic          ack, load_q, reset_q, tick_q, irq_q;
  logic [DW-1:0] rdat_q;

  // Next-value and decode signals
  logic          hit, req, wr;
  logic [2:0]    idx;
  logic          wr_ctrl, wr_load, wr_presc, wr_cmp, wr_status;
  logic          load_go, clear_go, match_set, reload_evt, tick_fire, running;
  logic [CW-1:0] load_merged, cmp_merged, presc_merged;
  logic          run_d, irq_en_d, auto_d, match_d, err_d;
  logic [CW-1:0] load_d, cmp_d, prescale_d, presc_d;
  logic [DW-1:0] rdata;
  logic          unused_bits;

  // Byte-lane merge of a 16-bit register with write data
  function automatic logic [CW-1:0] merge16(input logic [CW-1:0] old_v,
                                            input logic [CW-1:0] new_v,
                                            input logic [1:0]    be);
    logic [CW-1:0] r;
    r = old_v;
    if (be[0]) r[7:0]  = new_v[7:0];
    if (be[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  // True when every nibble is a legal decimal digit
  function automatic logic bcd_ok(input logic [CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Bus decode; the !ack term guarantees exactly one ack per access
  assign hit       = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign req       = wbs_stb_i & wbs_cyc_i & hit & ~ack;
  assign wr        = req & wbs_we_i;
  assign idx       = wbs_adr_i[4:2];
  assign wr_ctrl   = wr && (idx == 3'd0);
  assign wr_load   = wr && (idx == 3'd1);
  assign wr_presc  = wr && (idx == 3'd2);
  assign wr_cmp    = wr && (idx == 3'd3);
  assign wr_status = wr && (idx == 3'd5);

  assign load_go  = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[8];
  assign clear_go = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[9];

  assign load_merged  = merge16(load_reg,     wbs_dat_i[15:0], wbs_sel_i[1:0]);
  assign cmp_merged   = merge16(compare_reg,  wbs_dat_i[15:0], wbs_sel_i[1:0]);
  assign presc_merged = merge16(prescale_reg, wbs_dat_i[15:0], wbs_sel_i[1:0]);

  // Counter output is valid one cycle after each tick
  assign match_set  = sample_pend && (cnt_value == compare_reg);
  assign reload_evt = match_set & auto_reload;
  assign running    = (state != S_IDLE);

  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_adr_i[1:0]};

  // Register file next values; a match set beats a same-cycle W1C
  always_comb begin
    run_d      = run;
    irq_en_d   = irq_en;
    auto_d     = auto_reload;
    load_d     = load_reg;
    cmp_d      = compare_reg;
    prescale_d = prescale_reg;
    match_d    = match;
    err_d      = bcd_err;
    if (wr_ctrl && wbs_sel_i[0]) begin
      run_d    = wbs_dat_i[0];
      irq_en_d = wbs_dat_i[1];
      auto_d   = wbs_dat_i[2];
    end
    if (wr_load) begin
      if (bcd_ok(load_merged)) load_d = load_merged;
      else                     err_d  = 1'b1;
    end
    if (wr_cmp) begin
      if (bcd_ok(cmp_merged)) cmp_d = cmp_merged;
      else                    err_d = 1'b1;
    end
    if (wr_presc) prescale_d = presc_merged;
    if (wr_status && wbs_sel_i[0]) begin
      if (wbs_dat_i[0]) match_d = 1'b0;
      if (wbs_dat_i[1]) err_d   = 1'b0;
    end
    if (match_set) match_d = 1'b1;
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata = DW'({auto_reload, irq_en, run});
      3'd1:    rdata = DW'(load_reg);
      3'd2:    rdata = DW'(prescale_reg);
      3'd3:    rdata = DW'(compare_reg);
      3'd4:    rdata = DW'(cnt_value);
      3'd5:    rdata = DW'({running, bcd_err, match});
      default: rdata = '0;
    endcase
  end

  // Next state and prescaler; priority clear > load > auto-reload > tick
  always_comb begin
    state_next = state;
    tick_fire  = 1'b0;
    if (clear_go) begin
      state_next = S_CLEAR;
    end else if (load_go || reload_evt) begin
      state_next = S_LOAD;
    end else begin
      state_next = run ? S_RUN : S_IDLE;
      tick_fire  = (state == S_RUN) && (presc == prescale_reg);
    end

    if (wr_presc || tick_fire || (state != S_RUN) || (state_next != S_RUN))
      presc_d = '0;
    else
      presc_d = presc + CW'(1);
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  // Registers and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      run          <= 1'b0;
      irq_en       <= 1'b0;
      auto_reload  <= 1'b0;
      load_reg     <= '0;
      prescale_reg <= PRESCALE_RST;
      compare_reg  <= '0;
      match        <= 1'b0;
      bcd_err      <= 1'b0;
      presc        <= '0;
      sample_pend  <= 1'b0;
      ack          <= 1'b0;
      rdat_q       <= '0;
      load_q       <= 1'b0;
      reset_q      <= 1'b1;
      tick_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      run          <= run_d;
      irq_en       <= irq_en_d;
      auto_reload  <= auto_d;
      load_reg     <= load_d;
      prescale_reg <= prescale_d;
      compare_reg  <= cmp_d;
      match        <= match_d;
      bcd_err      <= err_d;
      presc        <= presc_d;
      sample_pend  <= tick_q;
      ack          <= req;
      rdat_q       <= (req && !wbs_we_i) ? rdata : '0;
      load_q       <= (state_next == S_LOAD);
      reset_q      <= (state_next == S_CLEAR);
      tick_q       <= tick_fire;
      irq_q        <= match_d & irq_en_d;
    end
  end

  assign wbs_ack_o      = ack;
  assign wbs_dat_o      = rdat_q;
  assign cnt_reset      = reset_q;
  assign cnt_load       = load_q;
  assign cnt_load_value = load_reg;
  assign cnt_tick       = tick_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Self-checking bench for bcd_counter_ctrl: models the BCD counter the
// controller drives and checks register, prescaler, compare and collision
// behaviour against expectations derived from the register map rules.
module tb_bcd_counter_ctrl;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [15:0] P_RST = 16'd0;

  logic        clk;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        cnt_reset, cnt_load, cnt_tick, irq;
  logic [15:0] cnt_load_value;
  logic [15:0] cnt_q = 16'h0;

  int checks   = 0;
  int failures = 0;
  int n_tick = 0, n_load = 0, n_rst = 0, n_overlap = 0;
  logic [15:0] last_load = 16'h0;

  // Register model used by the random register test
  logic        m_run, m_irq_en, m_auto, m_match, m_err;
  logic [15:0] m_load, m_presc, m_cmp;

  bcd_counter_ctrl dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wbs_stb_i      (stb),
    .wbs_cyc_i      (cyc),
    .wbs_we_i       (we),
    .wbs_sel_i      (sel),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (wdat),
    .wbs_ack_o      (ack),
    .wbs_dat_o      (rdat),
    .cnt_value      (cnt_q),
    .cnt_reset      (cnt_reset),
    .cnt_load       (cnt_load),
    .cnt_load_value (cnt_load_value),
    .cnt_tick       (cnt_tick),
    .irq_o          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic bit digits_legal(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] bytes_merge(input logic [15:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] r;
    r = o;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // The counter the controller drives, plus pulse bookkeeping
  always @(posedge clk) begin
    if (cnt_reset)     cnt_q <= 16'h0;
    else if (cnt_load) cnt_q <= cnt_load_value;
    else if (cnt_tick) cnt_q <= to_bcd((from_bcd(cnt_q) + 1) % 10000);
    if (cnt_tick)  n_tick <= n_tick + 1;
    if (cnt_load) begin n_load <= n_load + 1; last_load <= cnt_load_value; end
    if (cnt_reset) n_rst <= n_rst + 1;
    if ((cnt_tick && cnt_load) || (cnt_reset && (cnt_tick || cnt_load))) n_overlap <= n_overlap + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic acked);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; r = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; r = rdat; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic a;
    wb_xfer(1'b1, BASE | {27'd0, idx, 2'b00}, d, s, r, a);
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL wb_write_ack idx=%0d ack=%b required=1", idx, a); end
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] r);
    logic a;
    wb_xfer(1'b0, BASE | {27'd0, idx, 2'b00}, 32'h0, 4'hF, r, a);
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL wb_read_ack idx=%0d ack=%b required=1", idx, a); end
  endtask

  task automatic test_reset;
    logic [31:0] r, e;
    int t0;
    rst = 1'b1;
    cycles(3);
    checks++;
    if ({cnt_reset, cnt_tick, cnt_load, ack, irq} !== 5'b10000 || rdat !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs rst/tick/load/ack/irq=%b dat=%h required=10000 dat=0",
               {cnt_reset, cnt_tick, cnt_load, ack, irq}, rdat);
    end
    rst = 1'b0;
    cycles(1);
    checks++;
    if (cnt_reset !== 1'b0) begin failures++; $display("FAIL reset_release cnt_reset=%b required=0", cnt_reset); end
    t0 = n_tick;
    for (int i = 0; i < 8; i++) begin
      wb_read(3'(i), r);
      e = (i == 2) ? 32'(P_RST) : 32'h0;
      checks++;
      if (r !== e) begin failures++; $display("FAIL reset_reg idx=%0d got=%h required=%h", i, r, e); end
    end
    checks++;
    if (n_tick != t0) begin failures++; $display("FAIL reset_no_tick ticks=%0d required=0", n_tick - t0); end
    m_run = 0; m_irq_en = 0; m_auto = 0; m_match = 0; m_err = 0;
    m_load = 0; m_presc = P_RST; m_cmp = 0;
  endtask

  task automatic test_regs_random;
    logic [2:0]  idx;
    logic [3:0]  s;
    logic [31:0] d, r, e;
    logic [15:0] mg;
    for (int it = 0; it < 40; it++) begin
      idx = 3'($urandom_range(0, 7));
      s   = 4'($urandom);
      d   = $urandom;
      if (idx == 3'd0) d = d & 32'h2;
      if ((idx == 3'd1 || idx == 3'd3) && $urandom_range(0, 1) == 0)
        d = {d[31:16], to_bcd(int'($urandom_range(0, 9999)))};
      wb_write(idx, d, s);
      case (idx)
        3'd0: if (s[0]) begin m_run = d[0]; m_irq_en = d[1]; m_auto = d[2]; end
        3'd1: begin mg = bytes_merge(m_load, d, s); if (digits_legal(mg)) m_load = mg; else m_err = 1; end
        3'd2: m_presc = bytes_merge(m_presc, d, s);
        3'd3: begin mg = bytes_merge(m_cmp, d, s); if (digits_legal(mg)) m_cmp = mg; else m_err = 1; end
        3'd5: if (s[0]) begin if (d[0]) m_match = 0; if (d[1]) m_err = 0; end
        default: ;
      endcase
      case (idx)
        3'd0:    e = {29'd0, m_auto, m_irq_en, m_run};
        3'd1:    e = {16'd0, m_load};
        3'd2:    e = {16'd0, m_presc};
        3'd3:    e = {16'd0, m_cmp};
        3'd4:    e = {16'd0, cnt_q};
        3'd5:    e = {29'd0, 1'b0, m_err, m_match};
        default: e = 32'h0;
      endcase
      wb_read(idx, r);
      checks++;
      if (r !== e) begin failures++; $display("FAIL regs_random it=%0d idx=%0d got=%h required=%h", it, idx, r, e); end
      wb_read(3'd5, r);
      checks++;
      if (r !== {29'd0, 1'b0, m_err, m_match} || irq !== 1'b0) begin
        failures++; $display("FAIL regs_status it=%0d got=%h irq=%b required=%h irq=0", it, r, irq, {m_err, m_match});
      end
    end
    wb_write(3'd5, 32'h3, 4'h1);
    wb_write(3'd0, 32'h0, 4'h1);
  endtask

  task automatic test_miss;
    logic [31:0] r;
    logic a;
    wb_xfer(1'b1, BASE + 32'h24, 32'h0000_4321, 4'hF, r, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL miss_ack ack=%b required=0", a); end
    wb_read(3'd1, r);
    checks++;
    if (r !== {16'd0, m_load}) begin failures++; $display("FAIL miss_write got=%h required=%h", r, m_load); end
  endtask

  task automatic test_load;
    logic [15:0] v;
    logic [31:0] r;
    int l0;
    for (int k = 0; k < 3; k++) begin
      v = (k == 0) ? 16'h1234 : to_bcd(int'($urandom_range(0, 9999)));
      wb_write(3'd1, {16'd0, v}, 4'hF);
      l0 = n_load;
      wb_write(3'd0, 32'h100, 4'b0010);
      cycles(2);
      checks++;
      if (n_load - l0 != 1 || last_load !== v) begin
        failures++; $display("FAIL load_pulse pulses=%0d value=%h required=1 value=%h", n_load - l0, last_load, v);
      end
      wb_read(3'd4, r);
      checks++;
      if (r !== {16'd0, v}) begin failures++; $display("FAIL load_count got=%h required=%h", r, v); end
    end
    m_load = v;
  endtask

  task automatic test_prescale;
    int p, t0, t1, c0, exp_n;
    logic [31:0] r;
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 3 : int'($urandom_range(0, 6));
      wb_write(3'd2, 32'(p), 4'hF);
      wb_write(3'd0, 32'h1, 4'h1);
      cycles(3);
      wb_read(3'd5, r);
      checks++;
      if (r[2] !== 1'b1) begin failures++; $display("FAIL prescale_running got=%b required=1", r[2]); end
      t0 = n_tick; c0 = from_bcd(cnt_q);
      cycles(10 * (p + 1));
      checks++;
      if (n_tick - t0 != 10) begin failures++; $display("FAIL prescale_rate p=%0d ticks=%0d required=10", p, n_tick - t0); end
      wb_write(3'd0, 32'h0, 4'h1);
      cycles(3);
      t1 = n_tick;
      cycles(10);
      checks++;
      if (n_tick != t1) begin failures++; $display("FAIL prescale_stop ticks=%0d required=0", n_tick - t1); end
      exp_n = (c0 + (n_tick - t0)) % 10000;
      wb_read(3'd4, r);
      checks++;
      if (r !== {16'd0, to_bcd(exp_n)}) begin failures++; $display("FAIL prescale_count got=%h required=%h", r, to_bcd(exp_n)); end
    end
  endtask

  task automatic test_compare_irq;
    int c, l0, mx;
    logic [15:0] cb;
    bit seen, rose;
    logic [31:0] r;
    for (int k = 0; k < 2; k++) begin
      c  = (k == 0) ? 5 : int'($urandom_range(1, 40));
      cb = to_bcd(c);
      wb_write(3'd1, 32'h0, 4'hF);
      wb_write(3'd2, 32'h0, 4'hF);
      wb_write(3'd3, {16'd0, cb}, 4'hF);
      wb_write(3'd5, 32'h3, 4'h1);
      wb_write(3'd0, 32'h100, 4'b0010);
      cycles(2);
      l0 = n_load; mx = 0; seen = 0; rose = 0;
      wb_write(3'd0, 32'h7, 4'h1);
      for (int i = 0; i < 300; i++) begin
        if (cnt_q == cb) seen = 1;
        if (from_bcd(cnt_q) > mx) mx = from_bcd(cnt_q);
        if (irq === 1'b1) begin rose = 1; break; end
        cycles(1);
      end
      checks++;
      if (!rose || !seen || mx > c + 2) begin
        failures++; $display("FAIL compare_irq c=%0d irq=%0d seen=%0d max=%0d required irq=1 seen=1 max<=%0d", c, rose, seen, mx, c + 2);
      end
      cycles(4);
      checks++;
      if (n_load - l0 < 1 || last_load !== 16'h0) begin
        failures++; $display("FAIL auto_reload loads=%0d value=%h required>=1 value=0000", n_load - l0, last_load);
      end
      wb_write(3'd0, 32'h2, 4'h1);
      cycles(3);
      wb_read(3'd5, r);
      checks++;
      if (r[0] !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL match_hold match=%b irq=%b required=1 1", r[0], irq); end
      wb_write(3'd0, 32'h0, 4'h1);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_mask irq=%b required=0", irq); end
      wb_write(3'd0, 32'h2, 4'h1);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL irq_unmask irq=%b required=1", irq); end
      wb_write(3'd5, 32'h1, 4'h1);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c irq=%b required=0", irq); end
      wb_read(3'd5, r);
      checks++;
      if (r[0] !== 1'b0) begin failures++; $display("FAIL match_w1c match=%b required=0", r[0]); end
    end
    wb_write(3'd0, 32'h0, 4'h1);
  endtask

  task automatic test_wrap;
    bit rose;
    logic [31:0] r;
    wb_write(3'd1, 32'h9997, 4'hF);
    wb_write(3'd3, 32'h0, 4'hF);
    wb_write(3'd2, 32'h0, 4'hF);
    wb_write(3'd0, 32'h100, 4'b0010);
    cycles(2);
    wb_write(3'd0, 32'h3, 4'h1);
    rose = 0;
    for (int i = 0; i < 50; i++) begin
      if (irq === 1'b1) begin rose = 1; break; end
      cycles(1);
    end
    wb_write(3'd0, 32'h2, 4'h1);
    cycles(3);
    wb_read(3'd4, r);
    checks++;
    if (!rose || from_bcd(r[15:0]) > 9) begin
      failures++; $display("FAIL wrap_match irq=%0d count=%h required irq=1 count<0010", rose, r[15:0]);
    end
    wb_write(3'd5, 32'h3, 4'h1);
    wb_write(3'd0, 32'h0, 4'h1);
    m_load = 16'h9997;
  endtask

  task automatic test_bcd_err;
    logic [31:0] r;
    logic [15:0] bad;
    int nib;
    wb_write(3'd1, 32'h12A4, 4'hF);
    wb_read(3'd1, r);
    checks++;
    if (r !== {16'd0, m_load}) begin failures++; $display("FAIL bcd_load_kept got=%h required=%h", r, m_load); end
    wb_read(3'd5, r);
    checks++;
    if (r[1] !== 1'b1) begin failures++; $display("FAIL bcd_err_set got=%b required=1", r[1]); end
    wb_write(3'd5, 32'h2, 4'h1);
    wb_read(3'd5, r);
    checks++;
    if (r[1] !== 1'b0) begin failures++; $display("FAIL bcd_err_clr got=%b required=0", r[1]); end
    bad = to_bcd(int'($urandom_range(0, 9999)));
    nib = int'($urandom_range(0, 3));
    bad[4*nib +: 4] = 4'($urandom_range(10, 15));
    wb_write(3'd3, {16'd0, bad}, 4'hF);
    wb_read(3'd3, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL bcd_cmp_kept value=%h got=%h required=0", bad, r); end
    wb_read(3'd5, r);
    checks++;
    if (r[1] !== 1'b1) begin failures++; $display("FAIL bcd_err_cmp got=%b required=1", r[1]); end
    wb_write(3'd5, 32'h2, 4'h1);
  endtask

  task automatic test_collisions;
    logic [15:0] v;
    logic [31:0] r;
    int l0, ov0, r0;
    v = to_bcd(int'($urandom_range(0, 9999)));
    wb_write(3'd1, {16'd0, v}, 4'hF);
    wb_write(3'd2, 32'h0, 4'hF);
    wb_write(3'd0, 32'h1, 4'h1);
    cycles(5);
    l0 = n_load; ov0 = n_overlap;
    wb_write(3'd0, 32'h101, 4'b0011);
    cycles(3);
    checks++;
    if (n_load - l0 != 1 || n_overlap != ov0 || last_load !== v) begin
      failures++; $display("FAIL load_vs_tick loads=%0d overlaps=%0d value=%h required=1 0 %h", n_load - l0, n_overlap - ov0, last_load, v);
    end
    wb_write(3'd0, 32'h0, 4'h1);
    cycles(3);
    r0 = n_rst; l0 = n_load;
    wb_write(3'd0, 32'h300, 4'b0010);
    cycles(2);
    checks++;
    if (n_rst - r0 != 1 || n_load != l0) begin
      failures++; $display("FAIL clear_vs_load resets=%0d loads=%0d required=1 0", n_rst - r0, n_load - l0);
    end
    wb_read(3'd4, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL clear_count got=%h required=0", r); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] r;
    int t0;
    wb_write(3'd2, 32'h1, 4'hF);
    wb_write(3'd0, 32'h7, 4'h1);
    cycles(10);
    rst = 1'b1;
    cycles(1);
    checks++;
    if (cnt_tick !== 1'b0 || cnt_load !== 1'b0 || cnt_reset !== 1'b1) begin
      failures++; $display("FAIL midrun_reset tick=%b load=%b reset=%b required=0 0 1", cnt_tick, cnt_load, cnt_reset);
    end
    cycles(1);
    rst = 1'b0;
    cycles(2);
    t0 = n_tick;
    cycles(20);
    checks++;
    if (n_tick != t0) begin failures++; $display("FAIL midrun_ticks ticks=%0d required=0", n_tick - t0); end
    wb_read(3'd0, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL midrun_ctrl got=%h required=0", r); end
    wb_read(3'd5, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL midrun_status got=%h required=0", r); end
    wb_read(3'd2, r);
    checks++;
    if (r !== 32'(P_RST)) begin failures++; $display("FAIL midrun_prescale got=%h required=%h", r, P_RST); end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    test_reset();
    test_regs_random();
    test_miss();
    test_load();
    test_prescale();
    test_compare_irq();
    test_wrap();
    test_bcd_err();
    test_collisions();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
